// File: rtl/sram_responder.sv
// sram_responder: pin-level IS62WV25616-style SRAM emulation backed by on-chip RAM
module sram_responder #(
    parameter int          ADDR_BITS    = 18,
    parameter int          DEPTH_BITS   = 12,
    parameter int          READ_LATENCY = 1,
    parameter logic [15:0] STUCK_MASK   = 16'h0000,
    parameter logic [15:0] STUCK_VALUE  = 16'h0000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ADDR_BITS-1:0] address_pins,
    input  logic [15:0]          data_in,
    output logic [15:0]          data_out,
    output logic                 data_out_en,
    input  logic                 CS,
    input  logic                 OE,
    input  logic                 WE,
    output logic [15:0]          read_count,
    output logic [15:0]          write_count,
    output logic                 violation
);
    localparam int         DEPTH = 2 ** DEPTH_BITS;
    localparam logic [2:0] LAT   = 3'(READ_LATENCY);

    typedef enum logic [1:0] {IDLE, READ, DRIVE, WRITE} state_t;

    state_t                 state, state_nx;
    logic [ADDR_BITS-1:0]   addr, addr_nx;
    logic [15:0]            wdata, wdata_nx;
    logic [2:0]             cnt, cnt_nx;
    logic [15:0]            data_out_nx, read_count_nx, write_count_nx;
    logic                   en_nx, violation_nx, commit;
    logic                   rd_req, wr_req, addr_chg;
    logic [15:0]            fetch;
    logic [15:0]            mem [DEPTH];

    // WE overrides OE, so a write request ignores OE entirely
    assign rd_req   = !CS && !OE && WE;
    assign wr_req   = !CS && !WE;
    assign addr_chg = address_pins != addr;
    // Only the read path sees the stuck bits; stored data stays as written
    assign fetch    = (mem[addr[DEPTH_BITS-1:0]] & ~STUCK_MASK) | (STUCK_VALUE & STUCK_MASK);

    // Next-state and next-register values for the pin protocol
    always_comb begin
        state_nx       = state;
        addr_nx        = addr;
        wdata_nx       = wdata;
        cnt_nx         = cnt;
        data_out_nx    = data_out;
        en_nx          = data_out_en;
        read_count_nx  = read_count;
        write_count_nx = write_count;
        violation_nx   = violation | (wr_req && !OE);
        commit         = 1'b0;
        case (state)
            IDLE: begin
                if (wr_req) begin
                    state_nx = WRITE;
                    addr_nx  = address_pins;
                    wdata_nx = data_in;
                end else if (rd_req) begin
                    state_nx = READ;
                    addr_nx  = address_pins;
                    cnt_nx   = 3'd1;
                end
            end
            READ: begin
                if (wr_req) begin
                    state_nx = WRITE;
                    addr_nx  = address_pins;
                    wdata_nx = data_in;
                end else if (!rd_req) begin
                    state_nx = IDLE;
                end else if (addr_chg) begin
                    addr_nx = address_pins;
                    cnt_nx  = 3'd1;
                end else if (cnt == LAT) begin
                    state_nx      = DRIVE;
                    data_out_nx   = fetch;
                    en_nx         = 1'b1;
                    read_count_nx = read_count + 16'd1;
                end else begin
                    cnt_nx = cnt + 3'd1;
                end
            end
            DRIVE: begin
                if (wr_req) begin
                    state_nx = WRITE;
                    en_nx    = 1'b0;
                    addr_nx  = address_pins;
                    wdata_nx = data_in;
                end else if (!rd_req) begin
                    state_nx = IDLE;
                    en_nx    = 1'b0;
                end else if (addr_chg) begin
                    state_nx = READ;
                    en_nx    = 1'b0;
                    addr_nx  = address_pins;
                    cnt_nx   = 3'd1;
                end
            end
            WRITE: begin
                if (wr_req) begin
                    wdata_nx = data_in;
                    if (addr_chg) begin
                        addr_nx      = address_pins;
                        violation_nx = 1'b1;
                    end
                end else begin
                    commit         = 1'b1;
                    write_count_nx = write_count + 16'd1;
                    if (rd_req) begin
                        state_nx = READ;
                        addr_nx  = address_pins;
                        cnt_nx   = 3'd1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and output registers; reset drops the drive and discards a pending write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            addr        <= '0;
            wdata       <= '0;
            cnt         <= '0;
            data_out    <= '0;
            data_out_en <= 1'b0;
            read_count  <= '0;
            write_count <= '0;
            violation   <= 1'b0;
        end else begin
            state       <= state_nx;
            addr        <= addr_nx;
            wdata       <= wdata_nx;
            cnt         <= cnt_nx;
            data_out    <= data_out_nx;
            data_out_en <= en_nx;
            read_count  <= read_count_nx;
            write_count <= write_count_nx;
            violation   <= violation_nx;
        end
    end

    // Commit edge writes memory; a read fetch is always at least one edge later
    always_ff @(posedge clk) begin
        if (commit) mem[addr[DEPTH_BITS-1:0]] <= wdata;
    end
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed checks of three responder configurations sharing one pin bus
module tb_sram_responder;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [17:0] address_pins = '0;
    logic [15:0] data_in = '0;
    logic        CS = 1'b1, OE = 1'b1, WE = 1'b1;

    logic [15:0] a_dout, a_rc, a_wc, b_dout, b_rc, b_wc, c_dout, c_rc, c_wc;
    logic        a_en, a_vio, b_en, b_vio, c_en, c_vio;

    int checks = 0;
    int failures = 0;

    sram_responder u_a (
        .clk(clk), .reset_n(reset_n), .address_pins(address_pins), .data_in(data_in),
        .data_out(a_dout), .data_out_en(a_en), .CS(CS), .OE(OE), .WE(WE),
        .read_count(a_rc), .write_count(a_wc), .violation(a_vio)
    );

    sram_responder #(.STUCK_MASK(16'h2000), .STUCK_VALUE(16'h0000)) u_b (
        .clk(clk), .reset_n(reset_n), .address_pins(address_pins), .data_in(data_in),
        .data_out(b_dout), .data_out_en(b_en), .CS(CS), .OE(OE), .WE(WE),
        .read_count(b_rc), .write_count(b_wc), .violation(b_vio)
    );

    sram_responder #(.READ_LATENCY(3)) u_c (
        .clk(clk), .reset_n(reset_n), .address_pins(address_pins), .data_in(data_in),
        .data_out(c_dout), .data_out_en(c_en), .CS(CS), .OE(OE), .WE(WE),
        .read_count(c_rc), .write_count(c_wc), .violation(c_vio)
    );

    initial forever #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pins_idle();
        CS = 1'b1; OE = 1'b1; WE = 1'b1;
    endtask

    task automatic pins_write(input logic [17:0] a, input logic [15:0] d);
        CS = 1'b0; OE = 1'b1; WE = 1'b0; address_pins = a; data_in = d;
    endtask

    task automatic pins_read(input logic [17:0] a);
        CS = 1'b0; OE = 1'b0; WE = 1'b1; address_pins = a;
    endtask

    task automatic apply_reset();
        pins_idle();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        pins_idle();
        reset_n = 1'b0;
        step();
        step();
        checks++; if (a_dout !== 16'h0000) begin failures++; $display("FAIL reset_dout got=%h exp=0000", a_dout); end
        checks++; if (a_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", a_en); end
        checks++; if (a_rc !== 16'h0000) begin failures++; $display("FAIL reset_rc got=%h exp=0000", a_rc); end
        checks++; if (a_wc !== 16'h0000) begin failures++; $display("FAIL reset_wc got=%h exp=0000", a_wc); end
        checks++; if (a_vio !== 1'b0) begin failures++; $display("FAIL reset_vio got=%b exp=0", a_vio); end
        checks++; if (c_en !== 1'b0) begin failures++; $display("FAIL reset_en_c got=%b exp=0", c_en); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        apply_reset();
        pins_write(18'h00010, 16'hA5C3);
        step(); step(); step();
        pins_idle();
        step();
        checks++; if (a_wc !== 16'd1) begin failures++; $display("FAIL wr_count got=%h exp=0001", a_wc); end
        checks++; if (a_vio !== 1'b0) begin failures++; $display("FAIL wr_vio got=%b exp=0", a_vio); end
        pins_read(18'h00010);
        step();
        checks++; if (a_en !== 1'b0) begin failures++; $display("FAIL rd_en_early got=%b exp=0", a_en); end
        step();
        checks++; if (a_en !== 1'b1) begin failures++; $display("FAIL rd_en got=%b exp=1", a_en); end
        checks++; if (a_dout !== 16'hA5C3) begin failures++; $display("FAIL rd_data got=%h exp=a5c3", a_dout); end
        checks++; if (a_rc !== 16'd1) begin failures++; $display("FAIL rd_count got=%h exp=0001", a_rc); end
        step();
        checks++; if (a_en !== 1'b1) begin failures++; $display("FAIL rd_hold_en got=%b exp=1", a_en); end
        checks++; if (a_rc !== 16'd1) begin failures++; $display("FAIL rd_hold_count got=%h exp=0001", a_rc); end
        pins_idle();
        step();
        checks++; if (a_en !== 1'b0) begin failures++; $display("FAIL rd_release_en got=%b exp=0", a_en); end
        checks++; if (a_dout !== 16'hA5C3) begin failures++; $display("FAIL rd_release_data got=%h exp=a5c3", a_dout); end
    endtask

    task automatic test_alias();
        apply_reset();
        pins_write(18'h01005, 16'h1234);
        step();
        pins_idle();
        step();
        pins_read(18'h00005);
        step(); step();
        checks++; if (a_dout !== 16'h1234) begin failures++; $display("FAIL alias_data got=%h exp=1234", a_dout); end
        checks++; if (a_en !== 1'b1) begin failures++; $display("FAIL alias_en got=%b exp=1", a_en); end
        pins_idle();
        step();
    endtask

    task automatic test_stuck();
        apply_reset();
        pins_write(18'h00020, 16'hFFFF);
        step();
        pins_idle();
        step();
        pins_read(18'h00020);
        step(); step();
        checks++; if (b_dout !== 16'hDFFF) begin failures++; $display("FAIL stuck_data got=%h exp=dfff", b_dout); end
        checks++; if (b_en !== 1'b1) begin failures++; $display("FAIL stuck_en got=%b exp=1", b_en); end
        checks++; if (b_rc !== 16'd1) begin failures++; $display("FAIL stuck_count got=%h exp=0001", b_rc); end
        checks++; if (a_dout !== 16'hFFFF) begin failures++; $display("FAIL unstuck_data got=%h exp=ffff", a_dout); end
        address_pins = 18'h00010;
        step();
        checks++; if (a_en !== 1'b0) begin failures++; $display("FAIL addr_chg_en got=%b exp=0", a_en); end
        step();
        checks++; if (a_en !== 1'b1) begin failures++; $display("FAIL addr_chg_en2 got=%b exp=1", a_en); end
        checks++; if (a_dout !== 16'hA5C3) begin failures++; $display("FAIL addr_chg_data got=%h exp=a5c3", a_dout); end
        checks++; if (a_rc !== 16'd2) begin failures++; $display("FAIL addr_chg_count got=%h exp=0002", a_rc); end
        checks++; if (b_dout !== 16'h85C3) begin failures++; $display("FAIL stuck_data2 got=%h exp=85c3", b_dout); end
        pins_idle();
        step();
    endtask

    task automatic test_violation();
        apply_reset();
        CS = 1'b0; OE = 1'b0; WE = 1'b0; address_pins = 18'h00030; data_in = 16'h5A5A;
        step();
        checks++; if (a_vio !== 1'b1) begin failures++; $display("FAIL oe_we_vio got=%b exp=1", a_vio); end
        checks++; if (a_en !== 1'b0) begin failures++; $display("FAIL oe_we_en got=%b exp=0", a_en); end
        data_in = 16'h6B6B;
        step();
        pins_idle();
        step();
        checks++; if (a_wc !== 16'd1) begin failures++; $display("FAIL oe_we_commit got=%h exp=0001", a_wc); end
        checks++; if (a_vio !== 1'b1) begin failures++; $display("FAIL vio_sticky got=%b exp=1", a_vio); end
        pins_read(18'h00030);
        step(); step();
        checks++; if (a_dout !== 16'h6B6B) begin failures++; $display("FAIL oe_we_data got=%h exp=6b6b", a_dout); end
        apply_reset();
        checks++; if (a_vio !== 1'b0) begin failures++; $display("FAIL vio_cleared got=%b exp=0", a_vio); end
        pins_write(18'h00040, 16'h0001);
        step();
        checks++; if (a_vio !== 1'b0) begin failures++; $display("FAIL wr_clean_vio got=%b exp=0", a_vio); end
        pins_write(18'h00041, 16'h0002);
        step();
        checks++; if (a_vio !== 1'b1) begin failures++; $display("FAIL wr_addr_vio got=%b exp=1", a_vio); end
        pins_idle();
        step();
        checks++; if (a_wc !== 16'd1) begin failures++; $display("FAIL wr_addr_commit got=%h exp=0001", a_wc); end
        pins_read(18'h00041);
        step(); step();
        checks++; if (a_dout !== 16'h0002) begin failures++; $display("FAIL wr_addr_data got=%h exp=0002", a_dout); end
        pins_idle();
        step();
    endtask

    task automatic test_read_abort();
        apply_reset();
        pins_read(18'h00010);
        step(); step();
        pins_idle();
        step();
        checks++; if (c_en !== 1'b0) begin failures++; $display("FAIL abort_en got=%b exp=0", c_en); end
        checks++; if (c_rc !== 16'd0) begin failures++; $display("FAIL abort_count got=%h exp=0000", c_rc); end
        step();
        checks++; if (c_en !== 1'b0) begin failures++; $display("FAIL abort_en_late got=%b exp=0", c_en); end
        pins_read(18'h00010);
        step(); step(); step();
        checks++; if (c_en !== 1'b0) begin failures++; $display("FAIL lat3_en_early got=%b exp=0", c_en); end
        step();
        checks++; if (c_en !== 1'b1) begin failures++; $display("FAIL lat3_en got=%b exp=1", c_en); end
        checks++; if (c_dout !== 16'hA5C3) begin failures++; $display("FAIL lat3_data got=%h exp=a5c3", c_dout); end
        checks++; if (c_rc !== 16'd1) begin failures++; $display("FAIL lat3_count got=%h exp=0001", c_rc); end
        checks++; if (a_rc !== 16'd2) begin failures++; $display("FAIL lat1_count got=%h exp=0002", a_rc); end
        pins_idle();
        step();
    endtask

    task automatic test_reset_mid_write();
        apply_reset();
        pins_read(18'h00010);
        step(); step();
        reset_n = 1'b0;
        #1;
        checks++; if (a_en !== 1'b0) begin failures++; $display("FAIL async_en got=%b exp=0", a_en); end
        checks++; if (a_rc !== 16'd0) begin failures++; $display("FAIL async_rc got=%h exp=0000", a_rc); end
        pins_idle();
        step();
        reset_n = 1'b1;
        step();
        pins_write(18'h00010, 16'hDEAD);
        step(); step();
        reset_n = 1'b0;
        #1;
        checks++; if (a_wc !== 16'd0) begin failures++; $display("FAIL midwr_wc got=%h exp=0000", a_wc); end
        pins_idle();
        step();
        reset_n = 1'b1;
        step();
        checks++; if (a_wc !== 16'd0) begin failures++; $display("FAIL midwr_wc_after got=%h exp=0000", a_wc); end
        pins_read(18'h00010);
        step(); step();
        checks++; if (a_dout !== 16'hA5C3) begin failures++; $display("FAIL midwr_mem got=%h exp=a5c3", a_dout); end
        pins_idle();
        step();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        pins_write(18'h00060, 16'h1111);
        step();
        pins_idle();
        step();
        pins_write(18'h00060, 16'h2222);
        step();
        pins_idle();
        step(); step();
        pins_read(18'h00060);
        step(); step();
        checks++; if (a_dout !== 16'h2222) begin failures++; $display("FAIL b2b_data got=%h exp=2222", a_dout); end
        checks++; if (a_wc !== 16'd2) begin failures++; $display("FAIL b2b_wc got=%h exp=0002", a_wc); end
        pins_idle();
        step();
        pins_write(18'h00061, 16'h3333);
        step();
        pins_read(18'h00061);
        step(); step();
        checks++; if (a_dout !== 16'h3333) begin failures++; $display("FAIL raw_data got=%h exp=3333", a_dout); end
        checks++; if (a_en !== 1'b1) begin failures++; $display("FAIL raw_en got=%b exp=1", a_en); end
        checks++; if (a_wc !== 16'd3) begin failures++; $display("FAIL raw_wc got=%h exp=0003", a_wc); end
        checks++; if (a_rc !== 16'd2) begin failures++; $display("FAIL raw_rc got=%h exp=0002", a_rc); end
        pins_idle();
        step();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_alias();
        test_stuck();
        test_violation();
        test_read_abort();
        test_reset_mid_write();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
